// File: rtl/ed25519_pkg.sv
// Shared constants and state types for the Ed25519 job sequencer.
package ed25519_pkg;
  localparam int DATA_W    = 64;
  localparam int IN_WORDS  = 12;
  localparam int OUT_WORDS = 8;
  localparam int JOB_W     = 768;
  localparam int RES_W     = 512;
  localparam int IN_CNT_W  = 4;
  localparam int OUT_CNT_W = 3;

  typedef enum logic [1:0] {LOAD, LAUNCH, RUN} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;
endpackage

// File: rtl/ed25519_out_ser.sv
// Result serializer: captures the 512-bit core result and emits it MSW first as 64-bit valid/ready words.
//   state    | meaning
//   OUT_IDLE | buffer free, o_valid low
//   OUT_SEND | buffer holds a result, word r_cnt presented
module ed25519_out_ser
  import ed25519_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [RES_W-1:0]  i_res,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_idle
);
  out_state_t             r_state, w_next;
  logic [RES_W-1:0]       r_res;
  logic [OUT_CNT_W-1:0]   r_cnt;
  logic [OUT_CNT_W-1:0]   w_cnt_nxt;
  logic                   r_valid;
  logic [DATA_W-1:0]      r_data;
  logic                   w_hs;
  logic                   w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= OUT_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OUT_IDLE: if (i_load) w_next = OUT_SEND;
      OUT_SEND: if (w_hs && w_last) w_next = OUT_IDLE;
      default:  w_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    o_idle    = (r_state == OUT_IDLE);
    w_hs      = (r_state == OUT_SEND) & i_ready;
    w_last    = (r_cnt == OUT_CNT_W'(OUT_WORDS - 1));
    w_cnt_nxt = r_cnt + 1'b1;
  end

  // Output word is registered so it holds steady across stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_res   <= i_res;
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_data  <= i_res[RES_W-1 -: DATA_W];
    end else if (w_hs) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_data <= r_res[(OUT_WORDS - 1 - int'(w_cnt_nxt)) * DATA_W +: DATA_W];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/ed25519_io_sched.sv
// Job sequencer for the Ed25519 scalar-mult core: deserializes a 768-bit job, launches the core,
// guards it with a watchdog and hands the result to the output serializer.
//   state  | meaning
//   LOAD   | accepting job words 0..11
//   LAUNCH | job complete, waiting for a free output buffer to pulse start
//   RUN    | core busy, waiting for done or watchdog expiry
module ed25519_io_sched
  import ed25519_pkg::*;
#(
  parameter int TIMEOUT = 2**20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_core_start,
  output logic [JOB_W-1:0]  o_core_job,
  input  logic              i_core_done,
  input  logic [RES_W-1:0]  i_core_res,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_err
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  in_state_t             r_state, w_next;
  logic [IN_CNT_W-1:0]   r_in_cnt;
  logic [JOB_W-1:0]      r_job;
  logic [WD_W-1:0]       r_wd_cnt;
  logic                  r_in_ready;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_last_in;
  logic                  w_launch;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_out_idle;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= LOAD;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_last_in) w_next = LAUNCH;
      LAUNCH:  if (w_launch) w_next = RUN;
      RUN:     if (w_done || w_timeout) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_comb begin
    w_accept     = i_in_valid & r_in_ready;
    w_last_in    = w_accept & (r_in_cnt == IN_CNT_W'(IN_WORDS - 1));
    w_launch     = (r_state == LAUNCH) & w_out_idle;
    w_done       = (r_state == RUN) & i_core_done;
    w_timeout    = (r_state == RUN) & ~i_core_done & (TIMEOUT != 0) & (r_wd_cnt == '0);
    o_core_start = w_launch;
    o_busy       = (r_state != LOAD) | (r_in_cnt != '0) | ~w_out_idle;
  end

  // Ready is registered from next state, so it is low during reset and the first cycle after.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready <= 1'b0;
      r_in_cnt   <= '0;
      r_job      <= '0;
      r_wd_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= (w_next == LOAD);
      if (w_accept) begin
        r_job[(IN_WORDS - 1 - int'(r_in_cnt)) * DATA_W +: DATA_W] <= i_in_data;
        r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
      end
      if (w_launch)
        r_wd_cnt <= WD_W'(TIMEOUT - 1);
      else if ((r_state == RUN) && (r_wd_cnt != '0))
        r_wd_cnt <= r_wd_cnt - 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  ed25519_out_ser u_out_ser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_done),
    .i_res   (i_core_res),
    .i_ready (i_out_ready),
    .o_valid (o_out_valid),
    .o_data  (o_out_data),
    .o_idle  (w_out_idle)
  );

  assign o_in_ready = r_in_ready;
  assign o_core_job = r_job;
  assign o_err      = r_err;
endmodule

// File: tb/tb_ed25519_io_sched.sv
// Directed bench: default-watchdog instance for normal traffic, TIMEOUT=64 instance for the abort case.
module tb_ed25519_io_sched;
  localparam logic [767:0] JOB1 = {
    64'h259f4329e6f4590b, 64'h8c1d7e02a4b3f619, 64'h3e5a90c7d21f84b6, 64'hf0417a6c9e2db853,
    64'h5b8e1f03c47a692d, 64'ha7d2c6e91f305b84, 64'h164f9b3e7ac0d258, 64'hc93a0e5d82b7f416,
    64'h2e7b51f4d09c3a68, 64'h9d06c8a3e15f72b4, 64'h71e4a2d9b38c065f, 64'h6f1d2c3b11b0bea2};
  localparam logic [511:0] RES1 = {
    64'h47f6a5d15e1a0949, 64'h8b2ce07391d4f65a, 64'hd3190f6e2ab7c58e, 64'h5c7e84b0f1239d26,
    64'he81b4d9c63a07f15, 64'h09a6f3d27e5c18b4, 64'hb54d1e80c96f2a37, 64'h0c3e9b71a2f54468};

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic in_valid, out_ready, spur, hang;
  logic [63:0]  in_data;
  logic         core_done_m = 1'b0;
  logic [511:0] core_res = '0;
  logic [511:0] res_key;
  logic         core_done;
  int lat, cm_cnt = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, done_cyc = 0, start_in_send = 0;
  int last_acc, first_vcyc;
  int n_chk = 0, n_err = 0;

  logic a_in_ready, a_core_start, a_out_valid, a_busy, a_err;
  logic b_in_ready, b_core_start, b_out_valid, b_busy, b_err;
  logic [767:0] a_core_job, b_core_job;
  logic [63:0]  a_out_data, b_out_data;
  logic w_in_ready, w_core_start, w_out_valid, w_busy, w_err;
  logic [767:0] w_core_job;
  logic [63:0]  w_out_data;

  always #5 clk = ~clk;

  assign core_done    = core_done_m | spur;
  assign w_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign w_core_start = sel ? b_core_start : a_core_start;
  assign w_core_job   = sel ? b_core_job   : a_core_job;
  assign w_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign w_out_data   = sel ? b_out_data   : a_out_data;
  assign w_busy       = sel ? b_busy       : a_busy;
  assign w_err        = sel ? b_err        : a_err;

  ed25519_io_sched u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid & ~sel), .o_in_ready(a_in_ready),
    .i_in_data(in_data), .o_core_start(a_core_start), .o_core_job(a_core_job),
    .i_core_done(core_done & ~sel), .i_core_res(core_res), .o_out_valid(a_out_valid),
    .i_out_ready(out_ready & ~sel), .o_out_data(a_out_data), .o_busy(a_busy), .o_err(a_err));

  ed25519_io_sched #(.TIMEOUT(64)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid & sel), .o_in_ready(b_in_ready),
    .i_in_data(in_data), .o_core_start(b_core_start), .o_core_job(b_core_job),
    .i_core_done(core_done & sel), .i_core_res(core_res), .o_out_valid(b_out_valid),
    .i_out_ready(out_ready & sel), .o_out_data(b_out_data), .o_busy(b_busy), .o_err(b_err));

  // Core model: result = job[511:0] ^ res_key, read from the held job at completion time.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    core_done_m <= 1'b0;
    if (core_done) done_cyc <= cyc;
    if (w_core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      if (w_out_valid) start_in_send <= start_in_send + 1;
      if (!hang) cm_cnt <= lat;
    end else if (cm_cnt != 0) begin
      cm_cnt <= cm_cnt - 1;
      if (cm_cnt == 1) begin
        core_done_m <= 1'b1;
        core_res    <= w_core_job[511:0] ^ res_key;
      end
    end
  end

  task automatic chk(input string tag, input logic [767:0] act, input logic [767:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [767:0] job, input int nw, input int gap);
    for (int k = 0; k < nw; k++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = job[767 - 64*k -: 64];
      while (!w_in_ready && t < 4000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 4000) begin
        chk("in_timeout", k, nw);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      last_acc = cyc;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic [511:0] exp, input int duty, input int nmax, input string tag);
    int n, t;
    logic stalled;
    logic [63:0] held, ew;
    n = 0; t = 0; stalled = 1'b0; held = '0;
    first_vcyc = -1;
    while (n < nmax && t < 4000) begin
      @(negedge clk);
      t++;
      if (w_out_valid && first_vcyc < 0) first_vcyc = cyc;
      if (stalled) begin
        chk({tag, "_hold_v"}, w_out_valid, 1'b1);
        chk({tag, "_hold_d"}, w_out_data, held);
      end
      out_ready = ($urandom_range(99) < duty);
      stalled = 1'b0;
      if (w_out_valid) begin
        if (out_ready) begin
          ew = exp[511 - 64*n -: 64];
          chk({tag, "_word"}, w_out_data, ew);
          n++;
        end else begin
          stalled = 1'b1;
          held = w_out_data;
        end
      end
    end
    if (n < nmax) chk({tag, "_rx_timeout"}, n, nmax);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=%0d want=0", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic [767:0] job1, job2, job3;
    logic [511:0] exp1, exp2, exp3;
    int s0, t;
    in_valid = 0; in_data = '0; out_ready = 0; spur = 0; hang = 0; lat = 100; sel = 0; rst_n = 0;
    job1 = JOB1;
    res_key = job1[511:0] ^ RES1;
    job2 = {job1[383:0], job1[767:384]};
    job3 = ~job1;
    exp1 = job1[511:0] ^ res_key;
    exp2 = job2[511:0] ^ res_key;
    exp3 = job3[511:0] ^ res_key;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", w_in_ready, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_out_valid", w_out_valid, 0);
    chk("rst_out_data", w_out_data, 0);
    chk("rst_core_job", w_core_job, 0);
    chk("rst_err", w_err, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", w_in_ready, 1);

    // 1: single job, always-ready sink
    s0 = start_cnt;
    send(job1, 12, 0);
    chk("t1_start_now", w_core_start, 1);
    chk("t1_in_ready_low", w_in_ready, 0);
    @(negedge clk);
    chk("t1_start_once", w_core_start, 0);
    chk("t1_start_lat", start_cyc, last_acc);
    chk("t1_job", w_core_job, job1);
    recv(exp1, 100, 8, "t1");
    chk("t1_out_lat", first_vcyc, done_cyc + 1);
    chk("t1_nstart", start_cnt - s0, 1);

    // 2: 30% ready duty, busy drop after last handshake
    send(job1, 12, 0);
    chk("t2_busy_hi", w_busy, 1);
    recv(exp1, 30, 8, "t2");
    chk("t2_busy_drop", w_busy, 0);
    chk("t2_valid_drop", w_out_valid, 0);
    repeat (5) @(negedge clk);
    chk("t2_no_extra", w_out_valid, 0);

    // 3: second job loads while the first result drains
    s0 = start_cnt;
    send(job3, 12, 0);
    fork
      recv(exp3, 30, 8, "t3a");
      begin
        t = 0;
        while (!w_out_valid && t < 4000) begin @(negedge clk); t++; end
        send(job2, 12, 0);
        chk("t3_all_loaded", w_busy, 1);
      end
    join
    recv(exp2, 100, 8, "t3b");
    chk("t3_start_gated", start_in_send, 0);
    chk("t3_nstart", start_cnt - s0, 2);

    // 4: gapped input with spurious done pulses in LOAD
    s0 = start_cnt;
    fork
      send(job2, 12, 2);
      begin
        repeat (4) @(negedge clk);
        spur = 1; @(negedge clk); spur = 0; @(negedge clk);
        chk("t4_spur_ov1", w_out_valid, 0);
        repeat (10) @(negedge clk);
        spur = 1; @(negedge clk); spur = 0; @(negedge clk);
        chk("t4_spur_ov2", w_out_valid, 0);
      end
    join
    chk("t4_job", w_core_job, job2);
    recv(exp2, 100, 8, "t4");
    chk("t4_nstart", start_cnt - s0, 1);

    // 5: watchdog on the TIMEOUT=64 instance
    sel = 1; hang = 1;
    @(negedge clk);
    send(job1, 12, 0);
    chk("t5_start", w_core_start, 1);
    repeat (64) @(negedge clk);
    chk("t5_err_pre", w_err, 0);
    @(negedge clk);
    chk("t5_err_set", w_err, 1);
    chk("t5_in_ready", w_in_ready, 1);
    chk("t5_no_out", w_out_valid, 0);
    spur = 1; @(negedge clk); spur = 0; @(negedge clk);
    chk("t5_late_done", w_out_valid, 0);
    hang = 0; lat = 20;
    send(job3, 12, 0);
    recv(exp3, 100, 8, "t5");
    chk("t5_err_sticky", w_err, 1);
    sel = 0; lat = 100;
    @(negedge clk);

    // 6: async reset mid-load and mid-drain
    send(job1, 6, 0);
    chk("t6_busy_pre", w_busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t6a_in_ready", w_in_ready, 0);
    chk("t6a_busy", w_busy, 0);
    chk("t6a_core_job", w_core_job, 0);
    chk("t6a_start", w_core_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    send(job2, 12, 0);
    recv(exp2, 100, 3, "t6a");
    chk("t6_ov_pre", w_out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t6b_out_valid", w_out_valid, 0);
    chk("t6b_out_data", w_out_data, 0);
    chk("t6b_busy", w_busy, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    send(job3, 12, 0);
    recv(exp3, 100, 8, "t6c");
    chk("t6_busy_end", w_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
